// File: rtl/axi_lite_sram_slave_if.sv
// axi_lite_sram_slave_if
//   AXI-lite style bus between a load/store or fetch master and the SRAM
//   responder. Carries the five channels (AW, W, B, AR, R); clock and reset
//   are not part of the bundle.
//
//   Handshake rule for every channel: a transfer happens on a rising clock
//   edge where both valid and ready are high. Once a source raises valid it
//   keeps its payload stable until that edge. The slave side never derives
//   ready or valid combinationally from an input valid.
//
//   Modports:
//     master : drives awvalid/waddr, wvalid/wdata/wstrob, bready,
//              arvalid/raddr, rready
//     slave  : drives awready, wready, bvalid/bresp, arready, rvalid/rresp/rdata
interface axi_lite_sram_slave_if #(
    parameter int DATA_LEN     = 32,
    parameter int DATA_BIT_NUM = 4
);
    logic                    awvalid;
    logic                    awready;
    logic [DATA_LEN-1:0]     waddr;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_BIT_NUM-1:0] wstrob;
    logic [DATA_LEN-1:0]     wdata;
    logic                    bvalid;
    logic                    bready;
    logic [2:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_LEN-1:0]     raddr;
    logic                    rvalid;
    logic                    rready;
    logic [2:0]              rresp;
    logic [DATA_LEN-1:0]     rdata;

    modport master (
        output awvalid, waddr, wvalid, wstrob, wdata, bready,
               arvalid, raddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
    );

    modport slave (
        input  awvalid, waddr, wvalid, wstrob, wdata, bready,
               arvalid, raddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
    );
endinterface

// File: rtl/axi_lite_sram_slave.sv
// axi_lite_sram_slave
//   Word-organised on-chip SRAM behind an AXI-lite responder. Read and write
//   channels run independent FSMs; each channel can add an LFSR-driven random
//   latency (0..7 cycles) to stress initiator handshake paths.
//
//   Ports:
//     clk          clock
//     rst_n        asynchronous, active-low reset
//     bus          slave side of axi_lite_sram_slave_if (AW/W/B/AR/R channels)
//     r_state_dbg  current read FSM state  (0 idle, 1 delay, 2 resp)
//     w_state_dbg  current write FSM state (0 collect, 1 delay, 2 resp)
//
//   Addresses are byte addresses; the word index is addr[log2(MEM_DEPTH)+1:2]
//   and addr[1:0] is ignored. Addresses >= MEM_DEPTH*4 answer 3'b010 with no
//   memory write and zero read data. Memory contents are not reset.
module axi_lite_sram_slave #(
    parameter int         DATA_LEN     = 32,
    parameter int         DATA_BIT_NUM = 4,
    parameter int         MEM_DEPTH    = 256,
    parameter int         DELAY_EN     = 1,
    parameter logic [7:0] LFSR_SEED    = 8'h5A
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi_lite_sram_slave_if.slave bus,
    output logic [1:0]           r_state_dbg,
    output logic [1:0]           w_state_dbg
);
    localparam int                  IDX_W       = $clog2(MEM_DEPTH);
    localparam logic [DATA_LEN-1:0] ADDR_LIMIT  = DATA_LEN'(MEM_DEPTH * 4);
    localparam logic [2:0]          RESP_OKAY   = 3'b000;
    localparam logic [2:0]          RESP_SLVERR = 3'b010;
    localparam logic [7:0]          W_SEED      = {LFSR_SEED[3:0], LFSR_SEED[7:4]};

    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_COLLECT, W_DELAY, W_RESP} w_state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[4] ^ v[3] ^ v[2] ^ v[0], v[7:1]};
    endfunction

    logic [DATA_LEN-1:0] mem [MEM_DEPTH];

    // ---------------- read channel ----------------
    r_state_t            r_state;
    logic [DATA_LEN-1:0] r_addr;
    logic [2:0]          r_cnt;
    logic [7:0]          r_lfsr;
    logic [IDX_W-1:0]    r_idx;
    logic                r_in_range;

    assign r_idx       = r_addr[IDX_W+1:2];
    assign r_in_range  = (r_addr < ADDR_LIMIT);
    assign r_state_dbg = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= R_IDLE;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_lfsr      <= LFSR_SEED;
            bus.arready <= 1'b1;
            bus.rvalid  <= 1'b0;
            bus.rresp   <= RESP_OKAY;
            bus.rdata   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (bus.arvalid) begin
                        r_addr      <= bus.raddr;
                        // Delay is sampled before the LFSR steps.
                        r_cnt       <= (DELAY_EN != 0) ? r_lfsr[2:0] : 3'd0;
                        r_lfsr      <= lfsr_next(r_lfsr);
                        bus.arready <= 1'b0;
                        r_state     <= R_DELAY;
                    end
                end
                R_DELAY: begin
                    if (r_cnt == 3'd0) begin
                        // Same-cycle write commit is not yet visible: old data is returned.
                        bus.rdata  <= r_in_range ? mem[r_idx] : '0;
                        bus.rresp  <= r_in_range ? RESP_OKAY : RESP_SLVERR;
                        bus.rvalid <= 1'b1;
                        r_state    <= R_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                R_RESP: begin
                    if (bus.rready) begin
                        bus.rvalid  <= 1'b0;
                        bus.arready <= 1'b1;
                        r_state     <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // ---------------- write channel ----------------
    w_state_t                w_state;
    logic [DATA_LEN-1:0]     w_addr;
    logic [DATA_LEN-1:0]     w_data;
    logic [DATA_BIT_NUM-1:0] w_strb;
    logic                    aw_got;
    logic                    w_got;
    logic [2:0]              w_cnt;
    logic [7:0]              w_lfsr;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_in_range;
    logic                    aw_now;
    logic                    w_now;
    logic                    wr_commit;

    assign w_idx       = w_addr[IDX_W+1:2];
    assign w_in_range  = (w_addr < ADDR_LIMIT);
    assign w_state_dbg = w_state;
    // Handshakes this cycle; only possible while collecting.
    assign aw_now      = (w_state == W_COLLECT) && bus.awvalid && !aw_got;
    assign w_now       = (w_state == W_COLLECT) && bus.wvalid && !w_got;
    // Commit happens on the edge that raises bvalid; derived from registered
    // state only, so an asynchronous reset in W_DELAY suppresses it.
    assign wr_commit   = (w_state == W_DELAY) && (w_cnt == 3'd0) && w_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state     <= W_COLLECT;
            w_addr      <= '0;
            w_data      <= '0;
            w_strb      <= '0;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            w_cnt       <= '0;
            w_lfsr      <= W_SEED;
            bus.awready <= 1'b1;
            bus.wready  <= 1'b1;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_COLLECT: begin
                    if (aw_now) w_addr <= bus.waddr;
                    if (w_now) begin
                        w_data <= bus.wdata;
                        w_strb <= bus.wstrob;
                    end
                    // Counts handshakes landing on this edge so a same-cycle
                    // AW+W pair leaves for W_DELAY immediately.
                    if ((aw_got || aw_now) && (w_got || w_now)) begin
                        aw_got      <= 1'b0;
                        w_got       <= 1'b0;
                        bus.awready <= 1'b0;
                        bus.wready  <= 1'b0;
                        w_cnt       <= (DELAY_EN != 0) ? w_lfsr[2:0] : 3'd0;
                        w_lfsr      <= lfsr_next(w_lfsr);
                        w_state     <= W_DELAY;
                    end else begin
                        if (aw_now) begin
                            aw_got      <= 1'b1;
                            bus.awready <= 1'b0;
                        end
                        if (w_now) begin
                            w_got      <= 1'b1;
                            bus.wready <= 1'b0;
                        end
                    end
                end
                W_DELAY: begin
                    if (w_cnt == 3'd0) begin
                        bus.bresp  <= w_in_range ? RESP_OKAY : RESP_SLVERR;
                        bus.bvalid <= 1'b1;
                        w_state    <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt - 3'd1;
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        bus.bvalid  <= 1'b0;
                        bus.awready <= 1'b1;
                        bus.wready  <= 1'b1;
                        w_state     <= W_COLLECT;
                    end
                end
                default: w_state <= W_COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int i = 0; i < DATA_BIT_NUM; i++) begin
                if (w_strb[i]) mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// tb_axi_lite_sram_slave
//   dut0: DELAY_EN=0 (fixed latency), driven by tasks and checked by a
//   scoreboard monitor. dut1: DELAY_EN=1, LFSR_SEED=8'h5A, used for the random
//   latency and response-hold cases.
module tb_axi_lite_sram_slave;
    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;

    axi_lite_sram_slave_if #(.DATA_LEN(32), .DATA_BIT_NUM(4)) bus0 ();
    axi_lite_sram_slave_if #(.DATA_LEN(32), .DATA_BIT_NUM(4)) bus1 ();
    logic [1:0] r_dbg0, w_dbg0, r_dbg1, w_dbg1;

    axi_lite_sram_slave #(.DATA_LEN(32), .DATA_BIT_NUM(4), .MEM_DEPTH(256),
                          .DELAY_EN(0), .LFSR_SEED(8'h5A)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
        .r_state_dbg(r_dbg0), .w_state_dbg(w_dbg0));

    axi_lite_sram_slave #(.DATA_LEN(32), .DATA_BIT_NUM(4), .MEM_DEPTH(256),
                          .DELAY_EN(1), .LFSR_SEED(8'h5A)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
        .r_state_dbg(r_dbg1), .w_state_dbg(w_dbg1));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    // read entry: {expected rvalid cycle[15:0], rresp[2:0], rdata[31:0]}
    logic [50:0] exp_r_q[$];
    // write entry: {expected bvalid cycle[15:0], bresp[2:0]}
    logic [18:0] exp_b_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: act=%h req=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    int r0_rise;
    int b0_rise;
    logic r0_prev;
    logic b0_prev;
    initial begin
        r0_prev = 1'b0;
        b0_prev = 1'b0;
        r0_rise = 0;
        b0_rise = 0;
    end

    always @(negedge clk) begin
        logic [50:0] er;
        logic [18:0] eb;
        if (bus0.rvalid && !r0_prev) r0_rise = cyc;
        if (bus0.rvalid && bus0.rready) begin
            if (exp_r_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL r_unexpected: act=rvalid req=none rdata=%h", bus0.rdata);
            end else begin
                er = exp_r_q.pop_front();
                chk("r_data", bus0.rdata, er[31:0]);
                chk("r_resp", 32'(bus0.rresp), 32'(er[34:32]));
                chk("r_latency", 32'(r0_rise), 32'(er[50:35]));
            end
        end
        if (bus0.bvalid && !b0_prev) b0_rise = cyc;
        if (bus0.bvalid && bus0.bready) begin
            if (exp_b_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected: act=bvalid req=none bresp=%h", bus0.bresp);
            end else begin
                eb = exp_b_q.pop_front();
                chk("b_resp", 32'(bus0.bresp), 32'(eb[2:0]));
                chk("b_latency", 32'(b0_rise), 32'(eb[18:3]));
            end
        end
        r0_prev = bus0.rvalid;
        b0_prev = bus0.bvalid;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // w_lead: number of cycles W is presented before AW (0 = same cycle).
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int w_lead, input logic [2:0] resp);
        int  c;
        int  h;
        bit  aw_d;
        bit  w_d;
        bit  hs_aw;
        bit  hs_w;
        c = 0; h = 0; aw_d = 0; w_d = 0;
        bus0.wvalid = 1'b1;
        bus0.wdata  = d;
        bus0.wstrob = s;
        while (!(aw_d && w_d) && c < 50) begin
            if (w_d && !aw_d) begin
                chk("w_wready_low", 32'(bus0.wready), 32'd0);
                chk("w_awready_hold", 32'(bus0.awready), 32'd1);
            end
            if (!aw_d && c >= w_lead) begin
                bus0.awvalid = 1'b1;
                bus0.waddr   = a;
            end
            hs_aw = bus0.awvalid && bus0.awready;
            hs_w  = bus0.wvalid && bus0.wready;
            if (hs_aw) aw_d = 1;
            if (hs_w)  w_d  = 1;
            if (hs_aw || hs_w) h = cyc;
            tick();
            c++;
            if (aw_d) bus0.awvalid = 1'b0;
            if (w_d)  bus0.wvalid  = 1'b0;
        end
        if (!(aw_d && w_d)) begin
            total++;
            bad++;
            $display("FAIL w_handshake: act=timeout req=accept addr=%h", a);
            bus0.awvalid = 1'b0;
            bus0.wvalid  = 1'b0;
        end else begin
            exp_b_q.push_back({16'(h + 2), resp});
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [2:0] resp);
        int c;
        c = 0;
        bus0.arvalid = 1'b1;
        bus0.raddr   = a;
        while (!bus0.arready && c < 50) begin
            tick();
            c++;
        end
        if (!bus0.arready) begin
            total++;
            bad++;
            $display("FAIL ar_handshake: act=timeout req=accept addr=%h", a);
        end else begin
            exp_r_q.push_back({16'(cyc + 2), resp, d});
        end
        tick();
        bus0.arvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((exp_r_q.size() != 0 || exp_b_q.size() != 0) && c < 100) begin
            tick();
            c++;
        end
        tick();
        chk("idle_pending", 32'(exp_r_q.size() + exp_b_q.size()), 32'd0);
    endtask

    task automatic wait_rvalid1(output int rise);
        int c;
        c = 0;
        @(negedge clk);
        while (!bus1.rvalid && c < 50) begin
            @(negedge clk);
            c++;
        end
        rise = cyc;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_awready"}, 32'(bus0.awready), 32'd1);
        chk({tag, "_wready"},  32'(bus0.wready),  32'd1);
        chk({tag, "_arready"}, 32'(bus0.arready), 32'd1);
        chk({tag, "_bvalid"},  32'(bus0.bvalid),  32'd0);
        chk({tag, "_rvalid"},  32'(bus0.rvalid),  32'd0);
        chk({tag, "_bresp"},   32'(bus0.bresp),   32'd0);
        chk({tag, "_rresp"},   32'(bus0.rresp),   32'd0);
        chk({tag, "_rdata"},   bus0.rdata,        32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        int rise;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus0.awvalid = 0; bus0.waddr = 0; bus0.wvalid = 0; bus0.wstrob = 0;
        bus0.wdata = 0; bus0.bready = 1; bus0.arvalid = 0; bus0.raddr = 0; bus0.rready = 1;
        bus1.awvalid = 0; bus1.waddr = 0; bus1.wvalid = 0; bus1.wstrob = 0;
        bus1.wdata = 0; bus1.bready = 1; bus1.arvalid = 0; bus1.raddr = 0; bus1.rready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        tick();
        rst_n = 1'b1;
        tick();

        // Full-word write then read, AW and W together.
        wr(32'h10, 32'hDEADBEEF, 4'hF, 0, 3'b000);
        wait_idle();
        rd(32'h10, 32'hDEADBEEF, 3'b000);
        wait_idle();

        // Byte strobes 0101 over DEADBEEF.
        wr(32'h10, 32'h11223344, 4'b0101, 0, 3'b000);
        wait_idle();
        rd(32'h10, 32'hDE22BE44, 3'b000);
        wait_idle();

        // W leads AW by 3 cycles.
        wr(32'h14, 32'h55667788, 4'hF, 3, 3'b000);
        wait_idle();
        rd(32'h14, 32'h55667788, 3'b000);
        wait_idle();

        // Zero-strobe write is an OKAY no-op.
        wr(32'h14, 32'hFFFFFFFF, 4'h0, 0, 3'b000);
        wait_idle();
        rd(32'h14, 32'h55667788, 3'b000);
        wait_idle();

        // Out of range aliases word 0 by index; word 0 must stay untouched.
        wr(32'h0, 32'hCAFEF00D, 4'hF, 0, 3'b000);
        wait_idle();
        wr(32'h400, 32'h12345678, 4'hF, 0, 3'b010);
        wait_idle();
        rd(32'h400, 32'h0, 3'b010);
        wait_idle();
        rd(32'h0, 32'hCAFEF00D, 3'b000);
        wait_idle();

        // Last in-range word.
        wr(32'h3FC, 32'h01020304, 4'hF, 0, 3'b000);
        wait_idle();
        rd(32'h3FC, 32'h01020304, 3'b000);
        wait_idle();

        // dut1: random latency from LFSR seed 5A (d=2, then d=5).
        bus1.awvalid = 1; bus1.wvalid = 1; bus1.waddr = 32'h8;
        bus1.wdata = 32'h0BADCAFE; bus1.wstrob = 4'hF;
        tick();
        bus1.awvalid = 0; bus1.wvalid = 0;
        t = 0;
        while (!bus1.bvalid && t < 50) begin
            tick();
            t++;
        end
        chk("d1_bvalid", 32'(bus1.bvalid), 32'd1);
        tick();

        bus1.arvalid = 1; bus1.raddr = 32'h8;
        t = cyc;
        tick();
        bus1.arvalid = 0;
        wait_rvalid1(rise);
        chk("d1_lat_first", 32'(rise - t), 32'd4);
        chk("d1_rdata_first", bus1.rdata, 32'h0BADCAFE);
        chk("d1_rresp_first", 32'(bus1.rresp), 32'd0);
        tick();
        bus1.rready = 0;
        bus1.arvalid = 1;
        t = cyc;
        tick();
        bus1.arvalid = 0;
        wait_rvalid1(rise);
        chk("d1_lat_second", 32'(rise - t), 32'd7);
        for (int i = 0; i < 4; i++) begin
            chk("d1_hold_rvalid", 32'(bus1.rvalid), 32'd1);
            chk("d1_hold_rdata", bus1.rdata, 32'h0BADCAFE);
            chk("d1_hold_rresp", 32'(bus1.rresp), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus1.rready = 1;
        tick();
        chk("d1_rvalid_drop", 32'(bus1.rvalid), 32'd0);
        chk("d1_arready_back", 32'(bus1.arready), 32'd1);

        // Reset during W_DELAY drops the uncommitted write.
        wr(32'h20, 32'hA5A5A5A5, 4'hF, 0, 3'b000);
        wait_idle();
        rd(32'h20, 32'hA5A5A5A5, 3'b000);
        wait_idle();
        bus0.awvalid = 1; bus0.wvalid = 1; bus0.waddr = 32'h20;
        bus0.wdata = 32'hFFFF0000; bus0.wstrob = 4'hF;
        tick();
        bus0.awvalid = 0; bus0.wvalid = 0;
        chk("rst_in_wdelay", 32'(w_dbg0), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        rd(32'h20, 32'hA5A5A5A5, 3'b000);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
